ex_muldiv_unit: RTL

//  Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX register.

---
 rtl/ex_muldiv_unit_if.sv | 28 ++
 rtl/ex_muldiv_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: operand/result bundle between the ID/EX stage and the multiply/divide unit.
//   master (EX issue side): drives start, flush, funct3, op_a, op_b, rd_in;
//                           observes busy, done, result, rd_out.
//   slave  (muldiv unit)  : the reverse.
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per cycle, XLEN steps,
// followed by a sign-fixup cycle. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   io_mdu  slave modport of ex_muldiv_unit_if:
//     start/flush/funct3/op_a/op_b/rd_in in, busy/done/result/rd_out out
//   busy is the stall request; done is a one-cycle pulse qualifying result/rd_out.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input logic               clk,
  input logic               rst,
  ex_muldiv_unit_if.slave   io_mdu
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StSign, StDone} state_e;

  state_e          r_state;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_neg;
  logic [CntW-1:0] r_cnt;
  // r_hi:r_lo is the shared working register. Multiply: partial product high half, with the
  // multiplier shifting out of r_lo. Divide: partial remainder in r_hi, dividend shifting out
  // of r_lo while quotient bits shift in.
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [XLEN-1:0] r_opnd;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_rd_out;

  // Launch decode
  logic            w_is_div;
  logic            w_signed_a;
  logic            w_signed_b;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_neg;

  always_comb begin
    w_is_div   = io_mdu.funct3[2];
    w_signed_a = 1'b0;
    w_signed_b = 1'b0;
    case (io_mdu.funct3)
      3'b001, 3'b100, 3'b110: begin
        w_signed_a = 1'b1;
        w_signed_b = 1'b1;
      end
      3'b010: w_signed_a = 1'b1;
      default: ;
    endcase

    w_sa    = w_signed_a & io_mdu.op_a[XLEN-1];
    w_sb    = w_signed_b & io_mdu.op_b[XLEN-1];
    w_mag_a = w_sa ? (-io_mdu.op_a) : io_mdu.op_a;
    w_mag_b = w_sb ? (-io_mdu.op_b) : io_mdu.op_b;

    w_div_zero = w_is_div & (io_mdu.op_b == '0);
    // Signed overflow: most-negative / -1, only for DIV and REM.
    w_div_ovf  = w_is_div & ~io_mdu.funct3[0] &
                 (io_mdu.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (io_mdu.op_b == '1);
    w_special  = w_div_zero | w_div_ovf;

    if (w_div_zero) begin
      w_special_res = io_mdu.funct3[1] ? io_mdu.op_a : '1;
    end else begin
      w_special_res = io_mdu.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // Remainder follows the dividend; product and quotient follow sa^sb.
    if (w_is_div && io_mdu.funct3[1]) begin
      w_neg = w_sa;
    end else begin
      w_neg = w_sa ^ w_sb;
    end
  end

  // Iteration step
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN:0]   w_div_shift;
  logic [XLEN:0]   w_div_diff;
  logic [XLEN-1:0] w_hi_nxt;
  logic [XLEN-1:0] w_lo_nxt;

  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = {r_hi, r_lo[XLEN-1]};
    // Partial remainder stays below 2*divisor, so bit XLEN of the difference is its sign.
    w_div_diff  = w_div_shift - {1'b0, r_opnd};
    if (r_funct3[2]) begin
      if (!w_div_diff[XLEN]) begin
        w_hi_nxt = w_div_diff[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_div_shift[XLEN-1:0];
        w_lo_nxt = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[XLEN:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // Sign fixup and result select
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_final;

  always_comb begin
    w_prod   = {r_hi, r_lo};
    w_prod_s = r_neg ? (-w_prod) : w_prod;
    w_quo_s  = r_neg ? (-r_lo) : r_lo;
    w_rem_s  = r_neg ? (-r_hi) : r_hi;
    case (r_funct3)
      3'b000:                 w_final = w_prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_final = w_quo_s;
      default:                w_final = w_rem_s;
    endcase
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_neg    <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opnd   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_mdu.start && !io_mdu.flush) begin
            r_funct3 <= io_mdu.funct3;
            r_rd     <= io_mdu.rd_in;
            r_neg    <= w_neg;
            r_cnt    <= '0;
            if (w_special) begin
              r_state  <= StDone;
              r_done   <= 1'b1;
              r_result <= w_special_res;
              r_rd_out <= io_mdu.rd_in;
            end else begin
              r_state <= StCalc;
              r_busy  <= 1'b1;
              r_hi    <= '0;
              r_lo    <= w_is_div ? w_mag_a : w_mag_b;
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
            end
          end
        end
        StCalc: begin
          if (io_mdu.flush) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (r_cnt == CntW'(XLEN - 1)) begin
              r_state <= StSign;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StSign: begin
          r_busy <= 1'b0;
          if (io_mdu.flush) begin
            r_state <= StIdle;
          end else begin
            r_state  <= StDone;
            r_done   <= 1'b1;
            r_result <= w_final;
            r_rd_out <= r_rd;
          end
        end
        StDone: begin
          // start here is deliberately ignored; upstream re-issues after done.
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign io_mdu.busy   = r_busy;
  assign io_mdu.done   = r_done;
  assign io_mdu.result = r_result;
  assign io_mdu.rd_out = r_rd_out;

endmodule
